// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared core opcodes, canonical NOP and the fetch queue entry type
package fetch_unit_pkg;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous in-order queue of fetched {pc, instr} entries with flush
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  assign dout  = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with redirect flush; FETCH_BYPASS_EN presents responses same-cycle
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [6:0]  o_opcode,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_funct3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [6:0]  o_funct7
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);
  logic [31:0] fetch_pc, resp_pc, redirect_pc;
  logic [CW-1:0] outstanding, discard, count, in_flight;
  logic empty, full, grant, keep, bypass, push, pop;
  fetch_entry_t q_head;
  assign redirect_pc = i_redirect_pc & ~32'd3;
  assign o_imem_req  = i_rst_n && ({1'b0, outstanding} + {1'b0, count} < CAP);
  assign o_imem_addr = fetch_pc;
  assign grant       = o_imem_req && i_imem_gnt;
  assign keep        = i_rst_n && i_imem_rvalid && discard == '0;
  assign in_flight   = outstanding + CW'(grant) - CW'(i_imem_rvalid);
`ifdef FETCH_BYPASS_EN
  assign bypass = keep && empty;
`else
  assign bypass = 1'b0;
`endif
  assign push    = keep && !(bypass && i_ready) && !i_redirect && !full;
  assign pop     = i_ready && !empty;
  assign o_valid = !empty || bypass;
  assign o_pc    = bypass ? resp_pc : q_head.pc;
  assign o_instr = bypass ? i_imem_rdata : q_head.instr;
  assign o_opcode = o_instr[6:0];
  assign o_rd     = o_instr[11:7];
  assign o_funct3 = o_instr[14:12];
  assign o_rs1    = o_instr[19:15];
  assign o_rs2    = o_instr[24:20];
  assign o_funct7 = o_instr[31:25];
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .flush (i_redirect),
    .push  (push),
    .pop   (pop),
    .din   ({resp_pc, i_imem_rdata}),
    .dout  (q_head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= in_flight;
      if (i_redirect) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        discard  <= in_flight;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (keep) resp_pc <= resp_pc + 32'd4;
        if (i_imem_rvalid && discard != '0) discard <= discard - CW'(1);
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a PC-stream reference model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } flight_t;
  logic clk = 1'b0, rst_n = 1'b0, gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] rdata = '0, redirect_pc = '0;
  logic req, o_valid;
  logic [31:0] addr, o_pc, o_instr;
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  flight_t flight [$];
  fetch_entry_t exp_q [$];
  logic [31:0] exp_pc = RPC;
  int cyc = 0, total = 0, passed = 0, grant_cnt = 0, min_delay = 0, max_delay = 0;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_valid(o_valid), .i_ready(ready), .o_pc(o_pc), .o_instr(o_instr),
    .o_opcode(opcode), .o_rd(rd), .o_funct3(funct3), .o_rs1(rs1), .o_rs2(rs2), .o_funct7(funct7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_8113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] pick_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 4095));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input logic rs, input logic g, input logic r, input logic rdr, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = rs;
    gnt = g;
    ready = r;
    redirect = rdr;
    redirect_pc = rpc;
    rvalid = 1'b0;
    rdata = '0;
    if (!rs) begin
      flight.delete();
      exp_q.delete();
      exp_pc = RPC;
    end else if (flight.size() > 0 && flight[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata = mem_word(flight[0].addr);
      void'(flight.pop_front());
    end
    @(negedge clk);
    if (rs) begin
      if (req && gnt) flight.push_back('{addr: addr, due: cyc + 1 + min_delay + int'($urandom_range(0, max_delay))});
      if (rdr) begin
        exp_q.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end else if (req && gnt) begin
        grant_cnt++;
        chk("grant_addr", addr, exp_pc);
        exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
        exp_pc += 32'd4;
        chk("credit", 32'(exp_q.size() <= DEPTH), 32'd1);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() > 0 || flight.size() > 0); i++) step(1, 0, 1, 0, 0);
    chk("drain_left", 32'(exp_q.size() + flight.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst_n && o_valid && ready && !redirect) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_xfer: got pc %h, want no transfer (cycle %0d)", o_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_pc", o_pc, e.pc);
        chk("xfer_instr", o_instr, e.instr);
        chk("xfer_fields", {funct7, rs2, rs1, funct3, rd, opcode}, e.instr);
      end
    end
  end

  initial begin
    repeat (3) begin
      step(0, 0, 0, 0, 0);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
    end
    chk("rst_addr", addr, RPC);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    step(1, 1, 1, 0, 0);
    chk("first_req", 32'(req), 32'd1);
    chk("first_addr", addr, RPC);
    step(1, 1, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
    chk("bypass_valid", 32'(o_valid), 32'd1);
`else
    chk("reg_valid_early", 32'(o_valid), 32'd0);
    step(1, 1, 1, 0, 0);
    chk("reg_valid", 32'(o_valid), 32'd1);
`endif
    chk("first_opcode", 32'(opcode), 32'h13);
    chk("first_rd", 32'(rd), 32'd1);
    chk("first_rs2", 32'(rs2), 32'd10);
    repeat (20) step(1, 1, 1, 0, 0);
    drain();
    grant_cnt = 0;
    repeat (8) step(1, 1, 0, 0, 0);
    chk("bp_grants", 32'(grant_cnt), 32'(DEPTH));
    chk("bp_req", 32'(req), 32'd0);
    repeat (10) step(1, 1, 1, 0, 0);
    drain();
    min_delay = 3;
    grant_cnt = 0;
    repeat (2) step(1, 1, 1, 0, 0);
    chk("redir_inflight", 32'(grant_cnt), 32'd2);
    step(1, 0, 1, 1, 32'h0000_0102);
    step(1, 0, 1, 0, 0);
    chk("redir_addr", addr, 32'h0000_0100);
    min_delay = 0;
    repeat (12) step(1, 1, 1, 0, 0);
    drain();
    repeat (4) begin
      step(1, 0, 1, 0, 0);
      chk("stall_req", 32'(req), 32'd1);
      chk("stall_addr", addr, exp_pc);
    end
    min_delay = 5;
    repeat (2) step(1, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    min_delay = 0;
    step(1, 0, 1, 0, 0);
    chk("rst2_req", 32'(req), 32'd1);
    chk("rst2_addr", addr, RPC);
    drain();
    max_delay = 2;
    repeat (1500) step(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, pick_target());
    max_delay = 0;
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
